// File: rtl/bus_ic_pkg.sv
// Shared types and helpers for the round-robin bus interconnect.
// Index fields are sized for up to 16 hosts and 16 devices.
package bus_ic_pkg;

    localparam int unsigned HostIdxW = 4;
    localparam int unsigned DevIdxW  = 4;
    localparam int unsigned OneHotW  = 16;

    typedef struct packed {
        logic [HostIdxW-1:0] host;
        logic [DevIdxW-1:0]  dev;
    } outst_entry_t;

    function automatic logic [HostIdxW-1:0] onehot_to_idx(input logic [OneHotW-1:0] onehot);
        logic [HostIdxW-1:0] idx;
        idx = '0;
        for (int i = 0; i < OneHotW; i++) begin
            idx = onehot[i] ? HostIdxW'(i) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_ic_rr_arb.sv
// Round-robin arbiter: the winner is always visible, the grant only when enabled.
// The pointer moves past the granted host only on an actual grant.
module bus_ic_rr_arb #(
    parameter int unsigned NrHosts = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NrHosts-1:0] req_i,
    input  logic               en_i,
    output logic [NrHosts-1:0] winner_o,
    output logic [NrHosts-1:0] gnt_o
);

    localparam int unsigned PtrW = (NrHosts > 1) ? $clog2(NrHosts) : 1;

    logic [PtrW-1:0] r_ptr;
    logic [PtrW-1:0] w_win_idx;
    logic            w_found;
    logic            w_take;
    int unsigned     w_dist;
    int unsigned     w_best;

    // Pick the requester with the smallest distance from the pointer.
    always_comb begin
        w_win_idx = '0;
        w_found   = 1'b0;
        w_take    = 1'b0;
        w_best    = NrHosts;
        w_dist    = 0;
        for (int i = 0; i < NrHosts; i++) begin
            w_dist    = (32'(i) + NrHosts - 32'(r_ptr)) % NrHosts;
            w_take    = req_i[i] && (w_dist < w_best);
            w_best    = w_take ? w_dist : w_best;
            w_win_idx = w_take ? PtrW'(i) : w_win_idx;
            w_found   = w_found | w_take;
        end
        if (w_found) begin
            winner_o = NrHosts'(1) << w_win_idx;
        end else begin
            winner_o = '0;
        end
    end

    assign gnt_o = winner_o & {NrHosts{en_i & ~rst_i}};

    // Pointer advances to the host after the one just granted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (en_i && w_found) begin
            r_ptr <= (w_win_idx == PtrW'(NrHosts - 1)) ? '0 : w_win_idx + PtrW'(1);
        end
    end

endmodule

// File: rtl/bus_interconnect_rr.sv
// N-host / M-device interconnect with round-robin arbitration, in-order
// response tracking for pipelined requests, and an error slave for unmapped addresses.
module bus_interconnect_rr
    import bus_ic_pkg::*;
#(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned NrDevices      = 4,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NrHosts-1:0]        host_req_i,
    output logic [NrHosts-1:0]        host_gnt_o,
    input  logic [AddressWidth-1:0]   host_addr_i [NrHosts],
    input  logic [NrHosts-1:0]        host_we_i,
    input  logic [DataWidth/8-1:0]    host_be_i [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]        host_rvalid_o,
    output logic [DataWidth-1:0]      host_rdata_o [NrHosts],
    output logic [NrHosts-1:0]        host_err_o,
    output logic [NrDevices-1:0]      device_req_o,
    output logic [AddressWidth-1:0]   device_addr_o [NrDevices],
    output logic [NrDevices-1:0]      device_we_o,
    output logic [DataWidth/8-1:0]    device_be_o [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
    input  logic [NrDevices-1:0]      device_rvalid_i,
    input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
    input  logic [NrDevices-1:0]      device_err_i,
    input  logic [AddressWidth-1:0]   cfg_device_addr_base_i [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask_i [NrDevices],
    output logic                      resp_unexp_o
);

    localparam int unsigned HIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned DIdxW = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

    logic [NrHosts-1:0]      w_winner;
    logic [NrHosts-1:0]      w_gnt;
    logic [HostIdxW-1:0]     w_idx_full;
    logic [HIdxW-1:0]        w_win_idx;
    logic [AddressWidth-1:0] w_win_addr;
    logic                    w_dec_hit;
    logic                    w_match;
    logic [DIdxW-1:0]        w_dec_dev;
    logic                    w_issue_ok;
    logic                    w_grant;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_unexp;
    logic [CntW-1:0]         w_cnt_eff;
    outst_entry_t            w_new_entry;
    outst_entry_t            w_head;
    logic [DIdxW-1:0]        w_head_dev;
    logic [HIdxW-1:0]        w_head_host;
    logic                    w_unused;

    outst_entry_t            r_fifo [MaxOutstanding];
    logic [PtrW-1:0]         r_wptr;
    logic [PtrW-1:0]         r_rptr;
    logic [CntW-1:0]         r_count;
    logic [DIdxW-1:0]        r_tgt_dev;
    logic                    r_err_pending;
    logic [HIdxW-1:0]        r_err_host;
    logic                    r_resp_unexp;

    bus_ic_rr_arb #(
        .NrHosts (NrHosts)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (host_req_i),
        .en_i     (w_issue_ok),
        .winner_o (w_winner),
        .gnt_o    (w_gnt)
    );

    assign w_idx_full  = onehot_to_idx(OneHotW'(w_winner));
    assign w_win_idx   = w_idx_full[HIdxW-1:0];
    assign w_win_addr  = host_addr_i[w_win_idx];
    assign w_head      = r_fifo[r_rptr];
    assign w_head_dev  = w_head.dev[DIdxW-1:0];
    assign w_head_host = w_head.host[HIdxW-1:0];
    assign w_unused    = ^{w_idx_full, w_head};

    // Address decode of the arbitration winner; lowest matching index wins.
    always_comb begin
        w_dec_hit = 1'b0;
        w_dec_dev = '0;
        w_match   = 1'b0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            w_match   = (w_win_addr & cfg_device_addr_mask_i[d]) == cfg_device_addr_base_i[d];
            w_dec_dev = w_match ? DIdxW'(d) : w_dec_dev;
            w_dec_hit = w_dec_hit | w_match;
        end
    end

    assign w_pop     = (r_count != '0) & device_rvalid_i[w_head_dev] & ~rst_i;
    assign w_cnt_eff = r_count - CntW'(w_pop);

    // A pop in this cycle frees its slot before the issue decision is made.
    always_comb begin
        if (w_dec_hit) begin
            w_issue_ok = (w_cnt_eff != CntW'(MaxOutstanding)) &&
                         ((w_cnt_eff == '0) || (r_tgt_dev == w_dec_dev));
        end else begin
            w_issue_ok = (w_cnt_eff == '0) && !r_err_pending;
        end
    end

    assign w_grant    = |w_gnt;
    assign w_push     = w_grant & w_dec_hit;
    assign host_gnt_o = w_gnt;

    // Any response not from the head entry's device is dropped and flagged.
    always_comb begin
        w_unexp          = 1'b0;
        w_new_entry.host = HostIdxW'(w_win_idx);
        w_new_entry.dev  = DevIdxW'(w_dec_dev);
        for (int d = 0; d < NrDevices; d++) begin
            w_unexp = w_unexp | (device_rvalid_i[d] & ~((r_count != '0) && (w_head_dev == DIdxW'(d))));
        end
    end

    // Request fan-out to devices; payload is broadcast, req selects the target.
    always_comb begin
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = w_push && (w_dec_dev == DIdxW'(d));
            device_addr_o[d]  = w_win_addr;
            device_we_o[d]    = host_we_i[w_win_idx];
            device_be_o[d]    = host_be_i[w_win_idx];
            device_wdata_o[d] = host_wdata_i[w_win_idx];
        end
    end

    // Response demux: device response from the head entry, else the error slave.
    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_rvalid_o[h] = 1'b0;
            host_rdata_o[h]  = '0;
            host_err_o[h]    = 1'b0;
            if (w_pop && (w_head_host == HIdxW'(h))) begin
                host_rvalid_o[h] = 1'b1;
                host_rdata_o[h]  = device_rdata_i[w_head_dev];
                host_err_o[h]    = device_err_i[w_head_dev];
            end else if (r_err_pending && (r_err_host == HIdxW'(h))) begin
                host_rvalid_o[h] = 1'b1;
                host_err_o[h]    = 1'b1;
            end else begin
                host_rvalid_o[h] = 1'b0;
            end
        end
    end

    // Outstanding-transaction FIFO, error-slave state and the sticky flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_tgt_dev     <= '0;
            r_err_pending <= 1'b0;
            r_err_host    <= '0;
            r_resp_unexp  <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_new_entry;
                r_wptr         <= (r_wptr == PtrW'(MaxOutstanding - 1)) ? '0 : r_wptr + PtrW'(1);
                r_tgt_dev      <= w_dec_dev;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PtrW'(MaxOutstanding - 1)) ? '0 : r_rptr + PtrW'(1);
            end
            r_count       <= w_cnt_eff + CntW'(w_push);
            r_err_pending <= w_grant & ~w_dec_hit;
            if (w_grant && !w_dec_hit) begin
                r_err_host <= w_win_idx;
            end
            if (w_unexp) begin
                r_resp_unexp <= 1'b1;
            end
        end
    end

    assign resp_unexp_o = r_resp_unexp;

endmodule
